// File: rtl/jk_excitation_driver_if.sv
// ----------------------------------------------------------------------------
// jk_excitation_driver_if
//
// Purpose:
//   Groups the signals between the excitation driver, its control-side
//   producer and the JK flip-flop bank. The control side offers target words
//   on a valid/ready stream. The bank returns its live Q and receives J/K.
//
// Signals:
//   tgt_valid  control -> driver   target word present
//   tgt_ready  driver  -> control  driver can accept a target this cycle
//   tgt_data   control -> driver   desired next state of the JK bank
//   q_in       bank    -> driver   Q feedback from the JK bank
//   j_out      driver  -> bank     J inputs of the JK bank
//   k_out      driver  -> bank     K inputs of the JK bank
//
// Modports:
//   slave   the excitation driver's view
//   master  the environment's view (control logic plus bank)
// ----------------------------------------------------------------------------
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        input  q_in,
        output tgt_ready,
        output j_out,
        output k_out
    );

    modport master (
        output tgt_valid,
        output tgt_data,
        output q_in,
        input  tgt_ready,
        input  j_out,
        input  k_out
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// ----------------------------------------------------------------------------
// jk_excitation_driver
//
// Purpose:
//   Source end of a JK flip-flop register bank. The driver accepts one target
//   word at a time. It derives per-bit J/K excitation from the bank's Q at
//   the moment of acceptance and drives J/K for exactly one clock. It then
//   waits SETTLE_CYCLES idle cycles and checks that Q equals the target.
//   A failed check produces a one-cycle mismatch pulse and bumps a
//   saturating error counter.
//
// Parameters:
//   WIDTH          number of JK flip-flops / bits per target word
//   EXC_MODE       0: hold-style excitation, 1: toggle-style (J=K on change)
//   SETTLE_CYCLES  idle cycles between the J/K pulse and the Q check (>=0)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        jk_excitation_driver_if.slave (target stream, Q in, J/K out)
//   busy       high whenever the FSM is not IDLE
//   mismatch   one-cycle pulse: post-settle Q differed from the target
//   err_count  saturating count of mismatches
// ----------------------------------------------------------------------------
module jk_excitation_driver #(
    parameter int WIDTH         = 4,
    parameter int EXC_MODE      = 0,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    jk_excitation_driver_if.slave       bus,
    output logic                        busy,
    output logic                        mismatch,
    output logic [7:0]                  err_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK
    } state_t;

    // The settle counter only needs to reach SETTLE_CYCLES-1. A one-bit
    // counter is kept even when no settle cycles are requested so the
    // declarations stay legal.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] target_q,   target_d;
    logic [WIDTH-1:0] j_q,        j_d;
    logic [WIDTH-1:0] k_q,        k_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       err_q,      err_d;

    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;

    // Per-bit excitation from the live Q and the offered target word.
    // Hold-style drives J only for 0->1 and K only for 1->0, so J and K are
    // never both high. Toggle-style pulses J=K=1 on exactly the bits that
    // must change. In both styles a bit that already matches gets J=K=0.
    always_comb begin
        j_exc = '0;
        k_exc = '0;
        if (EXC_MODE == 1) begin
            j_exc = bus.q_in ^ bus.tgt_data;
            k_exc = bus.q_in ^ bus.tgt_data;
        end else begin
            j_exc = ~bus.q_in & bus.tgt_data;
            k_exc = bus.q_in & ~bus.tgt_data;
        end
    end

    // Next-state and next-output logic. J/K default to zero, so only the
    // acceptance edge loads a non-zero excitation. That value is therefore
    // visible for exactly the single DRIVE cycle. The mismatch flag also
    // defaults to zero, which makes it a one-cycle pulse after CHECK.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        j_d        = '0;
        k_d        = '0;
        cnt_d      = cnt_q;
        mismatch_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (bus.tgt_valid) begin
                    target_d = bus.tgt_data;
                    j_d      = j_exc;
                    k_d      = k_exc;
                    state_d  = DRIVE;
                end
            end

            DRIVE: begin
                cnt_d = '0;
                if (SETTLE_CYCLES == 0) begin
                    state_d = CHECK;
                end else begin
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CHECK: begin
                if (bus.q_in != target_q) begin
                    mismatch_d = 1'b1;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. A reset cycle abandons any word in flight
    // and clears the error history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            j_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            j_q        <= j_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    // tgt_ready follows the registered state, so the handshake has no
    // combinational path from tgt_valid.
    assign bus.tgt_ready = (state_q == IDLE);
    assign bus.j_out     = j_q;
    assign bus.k_out     = k_q;
    assign busy          = (state_q != IDLE);
    assign mismatch      = mismatch_q;
    assign err_count     = err_q;

    // J/K may only be non-zero while the bank is being driven.
    a_jk_only_in_drive : assert property (
        @(posedge clk) disable iff (reset)
        (state_q != DRIVE) |-> ((j_q == '0) && (k_q == '0))
    );

    // Hold-style excitation must never request a toggle on any bit.
    if (EXC_MODE == 0) begin : g_hold_check
        a_no_toggle : assert property (
            @(posedge clk) disable iff (reset)
            ((j_q & k_q) == '0)
        );
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// ----------------------------------------------------------------------------
// tb_jk_excitation_driver
//
// Purpose:
//   Directed bench for jk_excitation_driver. dut0 uses hold-style excitation
//   with one settle cycle and drives a small JK bank model. The model can be
//   preloaded or frozen to provoke mismatches. dut1 uses toggle-style
//   excitation with no settle cycles, and its Q is held by the bench.
// ----------------------------------------------------------------------------
module tb_jk_excitation_driver;

    logic clk;
    logic reset;

    logic       busy0, mismatch0;
    logic [7:0] err0;
    logic       busy1, mismatch1;
    logic [7:0] err1;

    logic [3:0] bank_q;
    logic       load_en;
    logic [3:0] load_val;
    logic       stuck;

    int cmp_count;
    int fail_count;
    int pulse_count;

    jk_excitation_driver_if #(.WIDTH(4)) bus0 ();
    jk_excitation_driver_if #(.WIDTH(4)) bus1 ();

    jk_excitation_driver #(
        .WIDTH         (4),
        .EXC_MODE      (0),
        .SETTLE_CYCLES (1)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus0),
        .busy      (busy0),
        .mismatch  (mismatch0),
        .err_count (err0)
    );

    jk_excitation_driver #(
        .WIDTH         (4),
        .EXC_MODE      (1),
        .SETTLE_CYCLES (0)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .busy      (busy1),
        .mismatch  (mismatch1),
        .err_count (err1)
    );

    assign bus0.q_in = bank_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // JK bank model behind dut0: Q+ = J&~Q | ~K&Q. It can be preloaded, or
    // frozen so that Q never reaches the target.
    always @(posedge clk) begin
        if (load_en) begin
            bank_q <= load_val;
        end else if (!stuck) begin
            bank_q <= (bus0.j_out & ~bank_q) | (~bus0.k_out & bank_q);
        end
    end

    // Counts the cycles in which dut0 reports a mismatch.
    always @(negedge clk) begin
        if (mismatch0) begin
            pulse_count = pulse_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        cmp_count = cmp_count + 1;
        if (actual !== expected) begin
            fail_count = fail_count + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadBank(input logic [3:0] value);
        load_en  = 1'b1;
        load_val = value;
        stepCycle();
        load_en  = 1'b0;
    endtask

    // Sends one word to dut0 and walks it through DRIVE, SETTLE and CHECK,
    // then checks the cycle that follows CHECK.
    task automatic applyStimulus(input string tag, input logic [3:0] data,
                                 input logic [3:0] exp_j, input logic [3:0] exp_k,
                                 input logic exp_mis, input logic [7:0] exp_err);
        checkOutput({tag, "_ready_idle"}, 32'(bus0.tgt_ready), 32'd1);
        bus0.tgt_valid = 1'b1;
        bus0.tgt_data  = data;
        stepCycle();
        bus0.tgt_valid = 1'b0;
        checkOutput({tag, "_drive_j"}, 32'(bus0.j_out), 32'(exp_j));
        checkOutput({tag, "_drive_k"}, 32'(bus0.k_out), 32'(exp_k));
        checkOutput({tag, "_drive_ready"}, 32'(bus0.tgt_ready), 32'd0);
        checkOutput({tag, "_drive_busy"}, 32'(busy0), 32'd1);
        stepCycle();
        checkOutput({tag, "_settle_jk"}, 32'({bus0.j_out, bus0.k_out}), 32'd0);
        checkOutput({tag, "_settle_busy"}, 32'(busy0), 32'd1);
        stepCycle();
        checkOutput({tag, "_check_jk"}, 32'({bus0.j_out, bus0.k_out}), 32'd0);
        checkOutput({tag, "_check_mis"}, 32'(mismatch0), 32'd0);
        checkOutput({tag, "_check_ready"}, 32'(bus0.tgt_ready), 32'd0);
        stepCycle();
        checkOutput({tag, "_post_mis"}, 32'(mismatch0), 32'(exp_mis));
        checkOutput({tag, "_post_err"}, 32'(err0), 32'(exp_err));
        checkOutput({tag, "_post_ready"}, 32'(bus0.tgt_ready), 32'd1);
        checkOutput({tag, "_post_busy"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        cmp_count      = 0;
        fail_count     = 0;
        pulse_count    = 0;
        reset          = 1'b1;
        load_en        = 1'b1;
        load_val       = 4'b0000;
        stuck          = 1'b0;
        bus0.tgt_valid = 1'b0;
        bus0.tgt_data  = 4'b0000;
        bus1.tgt_valid = 1'b0;
        bus1.tgt_data  = 4'b0000;
        bus1.q_in      = 4'b0110;
        repeat (3) stepCycle();
        reset   = 1'b0;
        load_en = 1'b0;

        // Reset state of both instances.
        checkOutput("rst_ready0", 32'(bus0.tgt_ready), 32'd1);
        checkOutput("rst_busy0", 32'(busy0), 32'd0);
        checkOutput("rst_jk0", 32'({bus0.j_out, bus0.k_out}), 32'd0);
        checkOutput("rst_mis0", 32'(mismatch0), 32'd0);
        checkOutput("rst_err0", 32'(err0), 32'd0);
        checkOutput("rst_ready1", 32'(bus1.tgt_ready), 32'd1);
        checkOutput("rst_err1", 32'(err1), 32'd0);

        // Hold-style set from Q=0000: J=1010, K=0000.
        applyStimulus("t1", 4'b1010, 4'b1010, 4'b0000, 1'b0, 8'd0);

        // Hold-style clear from Q=1111: J=0000, K=1010; the bank follows.
        loadBank(4'b1111);
        applyStimulus("t2", 4'b0101, 4'b0000, 4'b1010, 1'b0, 8'd0);
        checkOutput("t2_bank", 32'(bank_q), 32'b0101);

        // Toggle-style with no settle cycles: Q=0110, target 0011 -> J=K=0101.
        bus1.tgt_valid = 1'b1;
        bus1.tgt_data  = 4'b0011;
        stepCycle();
        bus1.tgt_valid = 1'b0;
        checkOutput("t3_drive_j", 32'(bus1.j_out), 32'b0101);
        checkOutput("t3_drive_k", 32'(bus1.k_out), 32'b0101);
        checkOutput("t3_drive_busy", 32'(busy1), 32'd1);
        stepCycle();
        checkOutput("t3_check_jk", 32'({bus1.j_out, bus1.k_out}), 32'd0);
        checkOutput("t3_check_mis", 32'(mismatch1), 32'd0);
        checkOutput("t3_check_ready", 32'(bus1.tgt_ready), 32'd0);
        stepCycle();
        checkOutput("t3_post_mis", 32'(mismatch1), 32'd1);
        checkOutput("t3_post_err", 32'(err1), 32'd1);
        checkOutput("t3_post_ready", 32'(bus1.tgt_ready), 32'd1);
        bus1.tgt_valid = 1'b1;
        bus1.tgt_data  = 4'b0110;
        stepCycle();
        bus1.tgt_valid = 1'b0;
        checkOutput("t3_same_mis", 32'(mismatch1), 32'd0);
        checkOutput("t3_same_jk", 32'({bus1.j_out, bus1.k_out}), 32'd0);
        checkOutput("t3_same_busy", 32'(busy1), 32'd1);
        stepCycle();
        stepCycle();
        checkOutput("t3_same_post_mis", 32'(mismatch1), 32'd0);
        checkOutput("t3_same_post_err", 32'(err1), 32'd1);

        // Bank stuck at 0000: target 0001 mismatches once.
        loadBank(4'b0000);
        stuck = 1'b1;
        applyStimulus("t4", 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'd1);
        stepCycle();
        checkOutput("t4_single_pulse", 32'(mismatch0), 32'd0);
        stuck = 1'b0;

        // Reset during SETTLE while tgt_valid stays high.
        loadBank(4'b0000);
        bus0.tgt_valid = 1'b1;
        bus0.tgt_data  = 4'b0011;
        stepCycle();
        checkOutput("t6_drive_j", 32'(bus0.j_out), 32'b0011);
        checkOutput("t6_drive_ready", 32'(bus0.tgt_ready), 32'd0);
        stepCycle();
        checkOutput("t6_settle_ready", 32'(bus0.tgt_ready), 32'd0);
        checkOutput("t6_settle_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("t6_rst_ready", 32'(bus0.tgt_ready), 32'd1);
        checkOutput("t6_rst_busy", 32'(busy0), 32'd0);
        checkOutput("t6_rst_jk", 32'({bus0.j_out, bus0.k_out}), 32'd0);
        checkOutput("t6_rst_err", 32'(err0), 32'd0);
        checkOutput("t6_rst_mis", 32'(mismatch0), 32'd0);
        // Bank already reached 0011, so the re-accepted word needs J=K=0.
        stepCycle();
        bus0.tgt_valid = 1'b0;
        checkOutput("t6_reaccept_busy", 32'(busy0), 32'd1);
        checkOutput("t6_reaccept_jk", 32'({bus0.j_out, bus0.k_out}), 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("t6_check_mis", 32'(mismatch0), 32'd0);
        stepCycle();
        checkOutput("t6_post_mis", 32'(mismatch0), 32'd0);
        checkOutput("t6_post_err", 32'(err0), 32'd0);
        checkOutput("t6_post_ready", 32'(bus0.tgt_ready), 32'd1);

        // 300 mismatching words: err_count saturates at 255.
        pulse_count = 0;
        loadBank(4'b0000);
        stuck = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            applyStimulus("t5", 4'b0001, 4'b0001, 4'b0000, 1'b1,
                          (n > 255) ? 8'd255 : 8'(n));
        end
        stuck = 1'b0;
        stepCycle();
        checkOutput("t5_pulse_count", 32'(pulse_count), 32'd300);
        checkOutput("t5_err_final", 32'(err0), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
